// File: rtl/serial_slave_port_pkg.sv
// Shared definitions for the serial slave port.
//   state_t     : FSM state encoding (IDLE, ADDR, WDATA, REQ, RDATA)
//   MODE_READ   : smode/dmode value for a read
//   MODE_WRITE  : smode/dmode value for a write
//   cnt_width() : width of the frame bit counter for given address/data widths
package serial_slave_port_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_WDATA = 3'd2,
        ST_REQ   = 3'd3,
        ST_RDATA = 3'd4
    } state_t;

    localparam logic MODE_READ  = 1'b0;
    localparam logic MODE_WRITE = 1'b1;

    // The counter only ever reaches max(aw,dw)-1, so clog2(max) bits suffice.
    function automatic int cnt_width(input int aw, input int dw);
        int m;
        m = (aw > dw) ? aw : dw;
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/slave_shift_reg.sv
// Parameterised shift register used both as SIPO and PISO.
//   clk, rst : clock, synchronous active-high reset (clears q)
//   load/din : parallel load, takes priority over shift
//   shift/sin: shift right by one, sin enters at the MSB
//   q        : register contents; q[0] is the serial output bit
// Shifting right with the new bit at the MSB means an LSB-first stream of
// WIDTH bits ends up in natural bit order.
module slave_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             shift,
    input  logic             sin,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst)
            q <= '0;
        else if (load)
            q <= din;
        else if (shift)
            q <= {sin, q[WIDTH-1:1]};
    end

endmodule

// File: rtl/serial_slave_port.sv
// Slave-side endpoint of the bit-serial system bus.
// Deserialises address (and write data), performs one valid/ready access on
// the local device, and serialises read data back onto the bus.
//   clk, rst       : clock, synchronous active-high reset
//   swdata/smode   : serial request bits (LSB first) and op, qualified by mvalid
//   srdata/svalid  : serial read data (LSB first) and its valid
//   sready         : port idle and able to take a new frame
//   daddr/dwdata/dmode/dvalid, dready/drdata : device request/response
//
// state | meaning
// IDLE  | waiting for mvalid; first cycle captures addr bit 0 and smode
// ADDR  | shifting in remaining address bits
// WDATA | shifting in write data (writes only)
// REQ   | dvalid high until the device handshakes
// RDATA | shifting read data out on srdata
module serial_slave_port
    import serial_slave_port_pkg::*;
#(
    parameter int ADDR_WIDTH           = 16,
    parameter int DATA_WIDTH           = 8,
    parameter int SLAVE_MEM_ADDR_WIDTH = 12
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            swdata,
    input  logic                            smode,
    input  logic                            mvalid,
    output logic                            srdata,
    output logic                            svalid,
    output logic                            sready,
    output logic [SLAVE_MEM_ADDR_WIDTH-1:0] daddr,
    output logic [DATA_WIDTH-1:0]           dwdata,
    output logic                            dmode,
    output logic                            dvalid,
    input  logic                            dready,
    input  logic [DATA_WIDTH-1:0]           drdata
);

    localparam int AW = SLAVE_MEM_ADDR_WIDTH;
    localparam int DW = DATA_WIDTH;
    localparam int CW = cnt_width(AW, DW);
    localparam logic [CW-1:0] A_LAST = CW'(AW - 1);
    localparam logic [CW-1:0] D_LAST = CW'(DW - 1);

    // The device-select bits are stripped upstream; the slave window must fit.
    if (SLAVE_MEM_ADDR_WIDTH > ADDR_WIDTH) begin : g_width_check
        $error("slave address wider than bus address");
    end

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic            mode_q, mode_n;
    logic            a_load, a_shift;
    logic            d_load, d_shift, d_sin;
    logic [DW-1:0]   d_din;
    logic [AW-1:0]   addr_q;
    logic [DW-1:0]   data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            mode_q <= MODE_READ;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            mode_q <= mode_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        mode_n  = mode_q;
        a_load  = 1'b0;
        a_shift = 1'b0;
        d_load  = 1'b0;
        d_shift = 1'b0;
        d_sin   = swdata;
        d_din   = '0;
        case (state)
            ST_IDLE: begin
                if (mvalid) begin
                    a_shift = 1'b1;
                    mode_n  = smode;
                    cnt_n   = CW'(1);
                    state_n = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (!mvalid) begin
                    // abort: clear the partial address
                    a_load  = 1'b1;
                    cnt_n   = '0;
                    state_n = ST_IDLE;
                end else begin
                    a_shift = 1'b1;
                    if (cnt == A_LAST) begin
                        cnt_n   = '0;
                        state_n = (mode_q == MODE_WRITE) ? ST_WDATA : ST_REQ;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
            end
            ST_WDATA: begin
                if (!mvalid) begin
                    a_load  = 1'b1;
                    d_load  = 1'b1;
                    cnt_n   = '0;
                    state_n = ST_IDLE;
                end else begin
                    d_shift = 1'b1;
                    if (cnt == D_LAST) begin
                        cnt_n   = '0;
                        state_n = ST_REQ;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
            end
            ST_REQ: begin
                if (dready) begin
                    cnt_n = '0;
                    if (mode_q == MODE_WRITE) begin
                        state_n = ST_IDLE;
                    end else begin
                        d_load  = 1'b1;
                        d_din   = drdata;
                        state_n = ST_RDATA;
                    end
                end
            end
            ST_RDATA: begin
                d_shift = 1'b1;
                d_sin   = 1'b0;
                if (cnt == D_LAST) begin
                    cnt_n   = '0;
                    state_n = ST_IDLE;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: begin
                state_n = ST_IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    slave_shift_reg #(.WIDTH(AW)) u_addr (
        .clk   (clk),
        .rst   (rst),
        .load  (a_load),
        .din   ('0),
        .shift (a_shift),
        .sin   (swdata),
        .q     (addr_q)
    );

    slave_shift_reg #(.WIDTH(DW)) u_data (
        .clk   (clk),
        .rst   (rst),
        .load  (d_load),
        .din   (d_din),
        .shift (d_shift),
        .sin   (d_sin),
        .q     (data_q)
    );

    // Valids are gated by rst so they drop in the reset cycle itself.
    assign dvalid = (state == ST_REQ) && !rst;
    assign svalid = (state == ST_RDATA) && !rst;
    assign sready = (state == ST_IDLE) || rst;
    assign srdata = svalid && data_q[0];
    assign daddr  = addr_q;
    assign dwdata = data_q;
    assign dmode  = mode_q;

endmodule

// File: tb/tb_serial_slave_port.sv
module tb_serial_slave_port;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        swdata = 1'b0;
    logic        smode = 1'b0;
    logic        mvalid = 1'b0;
    logic        srdata, svalid, sready, dmode, dvalid;
    logic [11:0] daddr;
    logic [7:0]  dwdata;
    logic        dready = 1'b0;
    logic [7:0]  drdata = 8'h00;

    int n_checks = 0;
    int n_fail   = 0;
    logic [20:0] hs_log[$];

    always #5 clk = ~clk;

    serial_slave_port #(
        .ADDR_WIDTH(16), .DATA_WIDTH(8), .SLAVE_MEM_ADDR_WIDTH(12)
    ) dut (
        .clk(clk), .rst(rst), .swdata(swdata), .smode(smode), .mvalid(mvalid),
        .srdata(srdata), .svalid(svalid), .sready(sready),
        .daddr(daddr), .dwdata(dwdata), .dmode(dmode), .dvalid(dvalid),
        .dready(dready), .drdata(drdata)
    );

    // Record every completed device handshake: {mode, addr, write data or 0}
    always @(posedge clk) begin
        if (dvalid && dready && !rst)
            hs_log.push_back({dmode, daddr, dmode ? dwdata : 8'h00});
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive abits address bits (abort if fewer than 12), then data for writes.
    // smode is inverted after the first bit to show only bit 0 counts.
    task automatic send_frame(input logic [11:0] a, input logic m,
                              input logic [7:0] d, input int abits);
        for (int i = 0; i < abits; i++) begin
            mvalid = 1'b1;
            swdata = a[i];
            smode  = (i == 0) ? m : ~m;
            tick();
        end
        if (abits == 12 && m) begin
            for (int i = 0; i < 8; i++) begin
                swdata = d[i];
                tick();
            end
        end
        mvalid = 1'b0;
        swdata = 1'b0;
        smode  = 1'b0;
    endtask

    // Handshake a read and check all 8 serial bits, then the return to idle.
    task automatic read_back(input string tag, input logic [7:0] rd);
        dready = 1'b1;
        drdata = rd;
        tick();
        dready = 1'b0;
        drdata = 8'h00;
        for (int i = 0; i < 8; i++) begin
            chk({tag, "_svalid"}, 32'(svalid), 32'd1);
            chk({tag, "_srdata"}, 32'(srdata), 32'(rd[i]));
            tick();
        end
        chk({tag, "_svalid_end"}, 32'(svalid), 32'd0);
        chk({tag, "_sready_end"}, 32'(sready), 32'd1);
    endtask

    initial begin
        logic [20:0] exp_log[7];
        int hs_before;

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        chk("rst_sready", 32'(sready), 32'd1);
        chk("rst_dvalid", 32'(dvalid), 32'd0);
        chk("rst_svalid", 32'(svalid), 32'd0);
        chk("rst_srdata", 32'(srdata), 32'd0);
        chk("rst_dmode",  32'(dmode),  32'd0);
        chk("rst_daddr",  32'(daddr),  32'd0);
        chk("rst_dwdata", 32'(dwdata), 32'd0);
        rst = 1'b0;
        tick();

        // Write 0x001 <- 0xA5, dready on first dvalid cycle
        send_frame(12'h001, 1'b1, 8'hA5, 12);
        chk("wr_dvalid", 32'(dvalid), 32'd1);
        chk("wr_daddr",  32'(daddr),  32'h001);
        chk("wr_dwdata", 32'(dwdata), 32'hA5);
        chk("wr_dmode",  32'(dmode),  32'd1);
        chk("wr_sready_busy", 32'(sready), 32'd0);
        dready = 1'b1;
        tick();
        dready = 1'b0;
        chk("wr_sready_after", 32'(sready), 32'd1);
        chk("wr_dvalid_after", 32'(dvalid), 32'd0);

        // Read 0x002, device returns 0x3C -> bits 0,0,1,1,1,1,0,0
        send_frame(12'h002, 1'b0, 8'h00, 12);
        chk("rd_dvalid", 32'(dvalid), 32'd1);
        chk("rd_daddr",  32'(daddr),  32'h002);
        chk("rd_dmode",  32'(dmode),  32'd0);
        read_back("rd", 8'h3C);

        // Device stall: 3 cycles of dready low
        send_frame(12'hABC, 1'b1, 8'h5A, 12);
        hs_before = hs_log.size();
        for (int i = 0; i < 3; i++) begin
            chk("stall_dvalid", 32'(dvalid), 32'd1);
            chk("stall_daddr",  32'(daddr),  32'hABC);
            chk("stall_dwdata", 32'(dwdata), 32'h5A);
            tick();
        end
        dready = 1'b1;
        tick();
        dready = 1'b0;
        chk("stall_sready", 32'(sready), 32'd1);
        chk("stall_one_hs", 32'(hs_log.size() - hs_before), 32'd1);

        // Abort after 5 address bits
        hs_before = hs_log.size();
        send_frame(12'h7FF, 1'b1, 8'hFF, 5);
        tick();
        chk("abort_sready", 32'(sready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            chk("abort_dvalid", 32'(dvalid), 32'd0);
            tick();
        end
        chk("abort_no_hs", 32'(hs_log.size() - hs_before), 32'd0);
        send_frame(12'h123, 1'b0, 8'h00, 12);
        chk("post_abort_dvalid", 32'(dvalid), 32'd1);
        chk("post_abort_daddr",  32'(daddr),  32'h123);
        read_back("post_abort", 8'h81);

        // Reset in RDATA after bit 3
        send_frame(12'h0F0, 1'b0, 8'h00, 12);
        dready = 1'b1;
        drdata = 8'hF5;
        tick();
        dready = 1'b0;
        drdata = 8'h00;
        for (int i = 0; i < 4; i++) begin
            chk("rrst_srdata", 32'(srdata), 32'(i == 0 || i == 2));
            tick();
        end
        rst = 1'b1;
        #1;
        chk("rrst_svalid_now", 32'(svalid), 32'd0);
        tick();
        rst = 1'b0;
        chk("rrst_svalid_next", 32'(svalid), 32'd0);
        chk("rrst_sready_next", 32'(sready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rrst_quiet", 32'({svalid, srdata}), 32'd0);
        end

        // Reset during REQ with dready high: handshake discarded
        send_frame(12'h055, 1'b1, 8'h11, 12);
        hs_before = hs_log.size();
        rst = 1'b1;
        dready = 1'b1;
        #1;
        chk("qrst_dvalid_now", 32'(dvalid), 32'd0);
        tick();
        rst = 1'b0;
        dready = 1'b0;
        chk("qrst_sready", 32'(sready), 32'd1);
        chk("qrst_no_hs", 32'(hs_log.size() - hs_before), 32'd0);
        tick();

        // Back-to-back write then read
        send_frame(12'h010, 1'b1, 8'h77, 12);
        dready = 1'b1;
        tick();
        dready = 1'b0;
        chk("b2b_sready", 32'(sready), 32'd1);
        send_frame(12'h020, 1'b0, 8'h00, 12);
        chk("b2b_rd_dvalid", 32'(dvalid), 32'd1);
        chk("b2b_rd_daddr",  32'(daddr),  32'h020);
        read_back("b2b", 8'h99);

        // Handshake order and contents
        exp_log[0] = {1'b1, 12'h001, 8'hA5};
        exp_log[1] = {1'b0, 12'h002, 8'h00};
        exp_log[2] = {1'b1, 12'hABC, 8'h5A};
        exp_log[3] = {1'b0, 12'h123, 8'h00};
        exp_log[4] = {1'b0, 12'h0F0, 8'h00};
        exp_log[5] = {1'b1, 12'h010, 8'h77};
        exp_log[6] = {1'b0, 12'h020, 8'h00};
        chk("hs_count", 32'(hs_log.size()), 32'd7);
        for (int i = 0; i < 7; i++) begin
            if (i < hs_log.size())
                chk("hs_entry", 32'(hs_log[i]), 32'(exp_log[i]));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
